// File: rtl/instr_fetch.sv
// Fetch unit: owns the PC and fetches from a combinational instruction ROM into a one-entry valid/ready output register.
// Latency: an instruction fetched in cycle N is presented to decode in cycle N+1. A redirect seen in cycle N fetches the target in N+1 and presents it in N+2.
// Backpressure: when if_ready_i is low and an entry is valid, the PC and the output register both hold.
//
// Ports:
//   clk_i, rst_i        clock (rising edge) and asynchronous active-high reset
//   imem_addr_o         byte address to the instruction ROM (always pc_q)
//   imem_data_i         instruction word returned combinationally for imem_addr_o
//   redirect_valid_i    redirect request (branch/jump/trap); highest priority
//   redirect_pc_i       redirect target
//   if_valid_o          output register holds an instruction
//   if_ready_i          decode accepts the entry this cycle
//   if_pc_o             PC of the delivered entry
//   if_instr_o          delivered instruction word
//   if_misalign_o       the entry is a misaligned-fetch exception marker
//   fetch_count_o       number of completed valid & ready handshakes
module instr_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [63:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_pc_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [63:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic        if_misalign_o,
    output logic [63:0] fetch_count_o
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic        exc_pending_q, exc_pending_d;
    logic [63:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [63:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_misalign_q, out_misalign_d;
    logic [63:0] count_q;

    logic accept;
    logic handshake;

    // The output register can take a new entry when it is empty or
    // when decode drains it this very cycle.
    assign accept    = !valid_q || if_ready_i;
    assign handshake = valid_q && if_ready_i;

    assign imem_addr_o   = pc_q;
    assign if_valid_o    = valid_q;
    assign if_pc_o       = out_pc_q;
    assign if_instr_o    = out_instr_q;
    assign if_misalign_o = out_misalign_q;
    assign fetch_count_o = count_q;

    always_comb begin
        state_d        = state_q;
        exc_pending_d  = exc_pending_q;
        pc_d           = pc_q;
        valid_d        = valid_q;
        out_pc_d       = out_pc_q;
        out_instr_d    = out_instr_q;
        out_misalign_d = out_misalign_q;

        if (redirect_valid_i) begin
            // Flush: the current entry is dropped, but if_pc_o keeps its last
            // value. A misaligned target parks fetch in HALT. One exception
            // entry is still owed to decode.
            valid_d        = 1'b0;
            out_instr_d    = NOP_INSTR;
            out_misalign_d = 1'b0;
            pc_d           = redirect_pc_i;
            if (redirect_pc_i[1:0] == 2'b00) begin
                state_d       = RUN;
                exc_pending_d = 1'b0;
            end else begin
                state_d       = HALT;
                exc_pending_d = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (accept) begin
                        valid_d        = 1'b1;
                        out_pc_d       = pc_q;
                        out_instr_d    = imem_data_i;
                        out_misalign_d = 1'b0;
                        pc_d           = pc_q + 64'd4;
                    end
                end
                HALT: begin
                    if (accept) begin
                        if (exc_pending_q) begin
                            // Deliver the exception marker once. Whatever the
                            // memory returned for the unaligned address is ignored.
                            valid_d        = 1'b1;
                            out_pc_d       = pc_q;
                            out_instr_d    = NOP_INSTR;
                            out_misalign_d = 1'b1;
                            exc_pending_d  = 1'b0;
                        end else if (valid_q) begin
                            // Exception entry consumed with nothing behind it.
                            valid_d        = 1'b0;
                            out_instr_d    = NOP_INSTR;
                            out_misalign_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= RUN;
            exc_pending_q  <= 1'b0;
            pc_q           <= RESET_PC;
            valid_q        <= 1'b0;
            out_pc_q       <= 64'h0;
            out_instr_q    <= NOP_INSTR;
            out_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            exc_pending_q  <= exc_pending_d;
            pc_q           <= pc_d;
            valid_q        <= valid_d;
            out_pc_q       <= out_pc_d;
            out_instr_q    <= out_instr_d;
            out_misalign_q <= out_misalign_d;
        end
    end

    // A handshake counts even on a redirect edge, because decode already owns that entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 64'h0;
        end else if (handshake) begin
            count_q <= count_q + 64'd1;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: a behavioural stream model checked every cycle, plus literal checks of the directed scenarios.
// Latency: the model is updated on each rising edge, and outputs are compared on the falling edge.
// Backpressure: if_ready is driven directed, then randomized.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        ready = 1'b1;

    logic [63:0] imem_addr, if_pc, fetch_count;
    logic [31:0] imem_data, if_instr;
    logic        if_valid, if_misalign;

    logic [63:0] imem_addr2, if_pc2, fetch_count2;
    logic [31:0] imem_data2, if_instr2;
    logic        if_valid2, if_misalign2;

    logic [31:0] rom [256];

    int nvec = 0;
    int nerr = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    assign imem_data  = rom[imem_addr[9:2]];
    assign imem_data2 = rom[imem_addr2[9:2]];

    instr_fetch dut (
        .clk_i(clk), .rst_i(rst), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .if_valid_o(if_valid), .if_ready_i(ready), .if_pc_o(if_pc),
        .if_instr_o(if_instr), .if_misalign_o(if_misalign), .fetch_count_o(fetch_count)
    );

    instr_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .imem_addr_o(imem_addr2), .imem_data_i(imem_data2),
        .redirect_valid_i(1'b0), .redirect_pc_i(64'h0),
        .if_valid_o(if_valid2), .if_ready_i(1'b1), .if_pc_o(if_pc2),
        .if_instr_o(if_instr2), .if_misalign_o(if_misalign2), .fetch_count_o(fetch_count2)
    );

    // Model: next fetch address, the entry visible to decode, and whether
    // fetch is parked on a misaligned target (with an exception still owed).
    typedef struct packed {
        logic [63:0] fetch_pc;
        logic        vis;
        logic [63:0] vis_pc;
        logic [31:0] vis_instr;
        logic        vis_mis;
        logic [63:0] count;
        logic        parked;
        logic        owed;
    } model_t;

    localparam model_t MODEL_RESET = '{fetch_pc: 64'h0, vis: 1'b0, vis_pc: 64'h0,
                                       vis_instr: NOP, vis_mis: 1'b0, count: 64'h0,
                                       parked: 1'b0, owed: 1'b0};

    model_t m;

    function automatic model_t model_step(model_t s, logic redir, logic [63:0] rpc, logic rdy);
        model_t n = s;
        logic   slot_free = !s.vis || rdy;
        if (s.vis && rdy) n.count = s.count + 64'd1;
        if (redir) begin
            n.vis = 1'b0; n.vis_instr = NOP; n.vis_mis = 1'b0;
            n.fetch_pc = rpc;
            n.parked = (rpc[1:0] != 2'b00);
            n.owed = n.parked;
        end else if (slot_free) begin
            if (!s.parked) begin
                n.vis = 1'b1; n.vis_pc = s.fetch_pc;
                n.vis_instr = rom[s.fetch_pc[9:2]]; n.vis_mis = 1'b0;
                n.fetch_pc = s.fetch_pc + 64'd4;
            end else if (s.owed) begin
                n.vis = 1'b1; n.vis_pc = s.fetch_pc; n.vis_instr = NOP;
                n.vis_mis = 1'b1; n.owed = 1'b0;
            end else if (s.vis) begin
                n.vis = 1'b0; n.vis_instr = NOP; n.vis_mis = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= MODEL_RESET;
        else     m <= model_step(m, redirect_valid, redirect_pc, ready);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model.valid", {63'b0, if_valid}, {63'b0, m.vis});
            chk("model.pc", if_pc, m.vis_pc);
            chk("model.instr", {32'b0, if_instr}, {32'b0, m.vis_instr});
            chk("model.misalign", {63'b0, if_misalign}, {63'b0, m.vis_mis});
            chk("model.count", fetch_count, m.count);
            chk("model.addr", imem_addr, m.fetch_pc);
        end
    end

    task automatic redirect_to(input logic [63:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc = tgt;
    endtask

    logic [63:0] exp_cnt;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[0] = 32'h0050_0093;
        rom[3] = 32'h00a0_0113;
        rom[6] = 32'h0020_81b3;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_en = 1'b1;
        chk("reset.valid", {63'b0, if_valid}, 64'd0);
        chk("reset.instr", {32'b0, if_instr}, {32'b0, NOP});
        chk("reset.count", fetch_count, 64'd0);
        chk("reset.addr", imem_addr, 64'd0);
        chk("reset.addr_wrapdut", imem_addr2, 64'hFFFF_FFFF_FFFF_FFFC);
        rst = 1'b0;

        // Straight-line fetch with ready held high.
        @(negedge clk);
        chk("t1.first_pc", if_pc, 64'h0);
        chk("t1.first_instr", {32'b0, if_instr}, 64'h0050_0093);
        chk("t5.pc_fffc", if_pc2, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        chk("t1.pc4", if_pc, 64'h4);
        chk("t5.wrap_pc0", if_pc2, 64'h0);
        chk("t5.wrap_valid", {63'b0, if_valid2}, 64'd1);
        repeat (2) @(negedge clk);
        chk("t1.pc_c_instr", {32'b0, if_instr}, 64'h00a0_0113);
        repeat (3) @(negedge clk);
        chk("t1.pc18", if_pc, 64'h18);
        chk("t1.pc18_instr", {32'b0, if_instr}, 64'h0020_81b3);

        // Stall while holding pc=0xC.
        redirect_to(64'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t2.at_c", if_pc, 64'hC);
        ready = 1'b0;
        exp_cnt = m.count;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2.stall_pc", if_pc, 64'hC);
            chk("t2.stall_instr", {32'b0, if_instr}, 64'h00a0_0113);
            chk("t2.stall_addr", imem_addr, 64'h10);
            chk("t2.stall_count", fetch_count, exp_cnt);
        end
        ready = 1'b1;
        @(negedge clk);
        chk("t2.release_pc", if_pc, 64'h10);

        // Redirect on the same edge as a handshake of the pc=8 entry.
        redirect_to(64'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3.at_8", if_pc, 64'h8);
        exp_cnt = m.count + 64'd1;
        redirect_to(64'h18);
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("t3.n1_valid", {63'b0, if_valid}, 64'd0);
        chk("t3.count", fetch_count, exp_cnt);
        @(negedge clk);
        chk("t3.n2_pc", if_pc, 64'h18);
        chk("t3.n2_instr", {32'b0, if_instr}, 64'h0020_81b3);

        // Misaligned redirect, followed by recovery.
        redirect_to(64'h1A);
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("t4.n1_valid", {63'b0, if_valid}, 64'd0);
        @(negedge clk);
        chk("t4.exc_valid", {63'b0, if_valid}, 64'd1);
        chk("t4.exc_pc", if_pc, 64'h1A);
        chk("t4.exc_instr", {32'b0, if_instr}, 64'h13);
        chk("t4.exc_mis", {63'b0, if_misalign}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4.halt_valid", {63'b0, if_valid}, 64'd0);
            chk("t4.halt_addr", imem_addr, 64'h1A);
        end
        redirect_to(64'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4.resume_pc", if_pc, 64'h0);
        chk("t4.resume_mis", {63'b0, if_misalign}, 64'd0);
        chk("t4.resume_valid", {63'b0, if_valid}, 64'd1);

        // Reset asserted mid-stall.
        ready = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6.valid", {63'b0, if_valid}, 64'd0);
        chk("t6.count", fetch_count, 64'd0);
        chk("t6.addr", imem_addr, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        chk("t6.restart_pc", if_pc, 64'h0);
        chk("t6.restart_valid", {63'b0, if_valid}, 64'd1);

        // Randomized phase: random backpressure, plus aligned and misaligned redirects.
        for (int i = 0; i < 2000; i++) begin
            ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = {54'b0, 8'($urandom_range(0, 255)),
                               ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
            end else begin
                redirect_valid = 1'b0;
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
